phy_cfg_seq: RTL and testbench
==============================

PHY_CFG_SEQ -- requirements
Module: phy_cfg_seq

Interface
REQ-001 Parameters SHALL be: DEPTH, default 32, init-table entries (2..64); PHY_ADDR, default 5'd0, PHY address presented with every access; STAT_REG, default 5'd31, vendor status register; TIMEOUT, default 4096, clocks allowed per MDIO phase.
REQ-002 clock  in  1  MDIO sequencer clock (2.5 MHz); the block SHALL use this single clock.
REQ-003 reset  in  1  reset, asynchronous and active-high.
REQ-004 init_request  in  1  pulse; requests a PHY re-initialisation.
REQ-005 allow_1Gbit  in  1  speed-selection jumper level; any change requests re-initialisation.
REQ-006 cfg_we / cfg_idx / cfg_reg / cfg_data  in  1/clog2(DEPTH)/5/16  init-table write port.
REQ-007 cfg_len  in  clog2(DEPTH)+1  number of table entries to play (0 = none).
REQ-008 mdio_phy / mdio_addr / mdio_wr_data  out  5/5/16  access target and write data.
REQ-009 mdio_rd_req / mdio_wr_req  out  1/1  access requests to the MDIO engine.
REQ-010 mdio_ready / mdio_rd_data  in  1/16  engine idle flag and read result.
REQ-011 speed / duplex / link  out  2/1/1  latest PHY status.
REQ-012 status_valid / init_done / busy / error / link_change  out  1 each  sequencer status; link_change is a 1-clock pulse.

Function
REQ-013 States SHALL be IDLE, INIT, POLL_STAT, POLL_LINK, ERR_WAIT.
REQ-014 Request handshake: a request SHALL be raised only while mdio_ready=1, held until mdio_ready samples 0, then dropped; the access completes on the first clock mdio_ready returns to 1.
REQ-015 Never more than one of mdio_rd_req / mdio_wr_req SHALL be high; mdio_phy/addr/wr_data SHALL be stable from request rise to completion.
REQ-016 INIT SHALL write table entries 0..cfg_len-1 in ascending order, one access each, then enter POLL_STAT and set init_done.
REQ-017 Any entry with cfg_reg=9 SHALL be written with bit 9 replaced by allow_1Gbit sampled at INIT entry; all other bits as stored.
REQ-018 cfg_len=0 SHALL skip INIT writes and set init_done directly.
REQ-019 POLL_STAT SHALL read STAT_REG: on completion speed<=rd_data[6:5], duplex<=rd_data[3]; then POLL_LINK.
REQ-020 POLL_LINK SHALL read register 1: link<=rd_data[2], status_valid<=1; then POLL_STAT; polling SHALL be continuous.
REQ-021 link_change SHALL pulse one clock when a completed register-1 read changes link.
REQ-022 A re-init request (init_request, or allow_1Gbit != value used by last INIT) SHALL be latched; it takes effect at the next access completion, and an in-flight access is never abandoned.
REQ-023 On taking effect: init_done<=0, status_valid<=0, restart INIT at entry 0; a request arriving during INIT restarts INIT after the current write.
REQ-024 cfg_we SHALL update the table in IDLE, POLL_STAT, POLL_LINK, and be ignored in INIT and ERR_WAIT.
REQ-025 Timeout: if mdio_ready fails to fall within TIMEOUT clocks of request rise, or fails to rise within TIMEOUT clocks of falling, error<=1, requests drop, state ERR_WAIT.
REQ-026 ERR_WAIT SHALL wait for mdio_ready=1 then restart INIT; error clears when the next INIT completes.
REQ-027 busy SHALL be 1 in INIT and ERR_WAIT, else 0.

Reset
REQ-028 During/after reset: all outputs 0 (speed 2'b00), table contents unchanged, state IDLE, re-init latched.
REQ-029 First clock after reset release with mdio_ready=1 SHALL enter INIT (startup initialisation without init_request).
REQ-030 Reset asserted mid-access SHALL drop requests immediately and discard the access.

Verification
REQ-031 cfg_len=3 table {9:0000,0:1300,0x0d:0002}, allow_1Gbit=1, engine model ready-drop after 2 clocks -> writes 9:0200, 0:1300, 0x0d:0002 in order, then init_done=1.
REQ-032 Model returns STAT_REG=0x0048, reg1=0x0004 -> speed=2'b10, duplex=1, link=1, status_valid=1, one link_change pulse.
REQ-033 Toggle allow_1Gbit during POLL_STAT read -> read completes, init_done falls, INIT replays with reg 9 bit 9 = new value.
REQ-034 Hold mdio_ready=1 after request (engine dead), TIMEOUT=16 -> error=1 at 16 clocks after request rise, busy=1, INIT restarts.
REQ-035 init_request during second INIT write -> write completes, INIT restarts from entry 0; cfg_we in INIT leaves table unchanged.
REQ-036 Assert reset mid-write -> requests 0 same cycle; after release INIT starts from entry 0.

Source files
------------

// File: rtl/phy_cfg_seq.sv
// MDIO configuration sequencer: replays a PHY init table after reset or on
// request, then polls the vendor status and link registers continuously.
module phy_cfg_seq #(
  parameter int         DEPTH    = 32,
  parameter logic [4:0] PHY_ADDR = 5'd0,
  parameter logic [4:0] STAT_REG = 5'd31,
  parameter int         TIMEOUT  = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     init_request,
  input  logic                     allow_1Gbit,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [4:0]               cfg_reg,
  input  logic [15:0]              cfg_data,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  output logic [4:0]               mdio_phy,
  output logic [4:0]               mdio_addr,
  output logic [15:0]              mdio_wr_data,
  output logic                     mdio_rd_req,
  output logic                     mdio_wr_req,
  input  logic                     mdio_ready,
  input  logic [15:0]              mdio_rd_data,
  output logic [1:0]               speed,
  output logic                     duplex,
  output logic                     link,
  output logic                     status_valid,
  output logic                     init_done,
  output logic                     busy,
  output logic                     error,
  output logic                     link_change
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, INIT, POLL_STAT, POLL_LINK, ERR_WAIT} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_REQ, PH_WAIT} phase_t;

  logic [4:0]  mem_reg [DEPTH];
  logic [15:0] mem_dat [DEPTH];

  state_t        state_q, state_d;
  phase_t        ph_q, ph_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          g1_q, g1_d, pend_q, pend_d;
  logic          rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [4:0]    phy_q, phy_d, addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    speed_q, speed_d;
  logic          duplex_q, duplex_d, link_q, link_d, sv_q, sv_d;
  logic          done_q, done_d, busy_q, busy_d, err_q, err_d, lchg_q, lchg_d;
  logic [4:0]    ent_reg;
  logic [15:0]   ent_dat;
  logic          reinit, acc_done, tmo, go_init;

  // Table is deliberately outside reset so its contents survive a PHY reset.
  always_ff @(posedge clock)
    if (cfg_we && state_q != INIT && state_q != ERR_WAIT) begin
      mem_reg[cfg_idx] <= cfg_reg;
      mem_dat[cfg_idx] <= cfg_data;
    end

  always_comb begin
    ent_reg = mem_reg[idx_q];
    ent_dat = mem_dat[idx_q];
    if (ent_reg == 5'd9) ent_dat[9] = g1_q;
  end

  always_comb begin
    state_d = state_q;  ph_d = ph_q;  tmr_d = tmr_q;  idx_d = idx_q;  g1_d = g1_q;
    rd_req_d = rd_req_q;  wr_req_d = wr_req_q;
    phy_d = phy_q;  addr_d = addr_q;  wdata_d = wdata_q;
    speed_d = speed_q;  duplex_d = duplex_q;  link_d = link_q;  sv_d = sv_q;
    done_d = done_q;  err_d = err_q;  lchg_d = 1'b0;
    reinit = pend_q | init_request | (allow_1Gbit != g1_q);
    pend_d = reinit;
    acc_done = 1'b0;  tmo = 1'b0;  go_init = 1'b0;

    case (ph_q)
      PH_IDLE:
        if (mdio_ready && (state_q == INIT || state_q == POLL_STAT || state_q == POLL_LINK)) begin
          ph_d     = PH_REQ;
          tmr_d    = '0;
          phy_d    = PHY_ADDR;
          rd_req_d = (state_q != INIT);
          wr_req_d = (state_q == INIT);
          addr_d   = (state_q == INIT) ? ent_reg : (state_q == POLL_STAT) ? STAT_REG : 5'd1;
          if (state_q == INIT) wdata_d = ent_dat;
        end
      PH_REQ:
        if (!mdio_ready) begin
          rd_req_d = 1'b0;  wr_req_d = 1'b0;  ph_d = PH_WAIT;  tmr_d = '0;
        end else if (tmr_q == TMAX) tmo = 1'b1;
        else tmr_d = tmr_q + 1'b1;
      PH_WAIT:
        if (mdio_ready) begin
          acc_done = 1'b1;  ph_d = PH_IDLE;
        end else if (tmr_q == TMAX) tmo = 1'b1;
        else tmr_d = tmr_q + 1'b1;
      default: ph_d = PH_IDLE;
    endcase

    if (tmo) begin
      rd_req_d = 1'b0;  wr_req_d = 1'b0;  ph_d = PH_IDLE;
      err_d = 1'b1;  state_d = ERR_WAIT;
    end

    if (acc_done)
      case (state_q)
        INIT:
          if (reinit) go_init = 1'b1;
          else if (LW'(idx_q) + LW'(1) >= cfg_len) begin
            state_d = POLL_STAT;  done_d = 1'b1;  err_d = 1'b0;
          end else idx_d = idx_q + 1'b1;
        POLL_STAT: begin
          speed_d  = mdio_rd_data[6:5];
          duplex_d = mdio_rd_data[3];
          if (reinit) go_init = 1'b1;
          else state_d = POLL_LINK;
        end
        POLL_LINK: begin
          link_d = mdio_rd_data[2];
          lchg_d = (mdio_rd_data[2] != link_q);
          sv_d   = 1'b1;
          if (reinit) go_init = 1'b1;
          else state_d = POLL_STAT;
        end
        default: ;
      endcase

    if ((state_q == IDLE || state_q == ERR_WAIT) && mdio_ready) go_init = 1'b1;

    // allow_1Gbit is captured here and used for every reg-9 write of this pass.
    if (go_init) begin
      idx_d = '0;  g1_d = allow_1Gbit;  pend_d = 1'b0;
      done_d = 1'b0;  sv_d = 1'b0;
      if (cfg_len == '0) begin
        state_d = POLL_STAT;  done_d = 1'b1;  err_d = 1'b0;
      end else state_d = INIT;
    end

    busy_d = (state_d == INIT || state_d == ERR_WAIT);
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;  ph_q <= PH_IDLE;  tmr_q <= '0;  idx_q <= '0;
      g1_q <= 1'b0;  pend_q <= 1'b1;
      rd_req_q <= 1'b0;  wr_req_q <= 1'b0;
      phy_q <= '0;  addr_q <= '0;  wdata_q <= '0;
      speed_q <= 2'b00;  duplex_q <= 1'b0;  link_q <= 1'b0;  sv_q <= 1'b0;
      done_q <= 1'b0;  busy_q <= 1'b0;  err_q <= 1'b0;  lchg_q <= 1'b0;
    end else begin
      state_q <= state_d;  ph_q <= ph_d;  tmr_q <= tmr_d;  idx_q <= idx_d;
      g1_q <= g1_d;  pend_q <= pend_d;
      rd_req_q <= rd_req_d;  wr_req_q <= wr_req_d;
      phy_q <= phy_d;  addr_q <= addr_d;  wdata_q <= wdata_d;
      speed_q <= speed_d;  duplex_q <= duplex_d;  link_q <= link_d;  sv_q <= sv_d;
      done_q <= done_d;  busy_q <= busy_d;  err_q <= err_d;  lchg_q <= lchg_d;
    end

  assign mdio_phy     = phy_q;
  assign mdio_addr    = addr_q;
  assign mdio_wr_data = wdata_q;
  assign mdio_rd_req  = rd_req_q;
  assign mdio_wr_req  = wr_req_q;
  assign speed        = speed_q;
  assign duplex       = duplex_q;
  assign link         = link_q;
  assign status_valid = sv_q;
  assign init_done    = done_q;
  assign busy         = busy_q;
  assign error        = err_q;
  assign link_change  = lchg_q;
endmodule

// File: tb/tb_phy_cfg_seq.sv
// Bench for phy_cfg_seq: an MDIO engine model logs every access; each test
// pushes the accesses it expects and compares them against the log.
module tb_phy_cfg_seq;
  logic        clock = 1'b0, reset = 1'b0;
  logic        init_request, allow_1Gbit, cfg_we;
  logic [4:0]  cfg_idx, cfg_reg;
  logic [15:0] cfg_data;
  logic [5:0]  cfg_len;
  logic [4:0]  mdio_phy, mdio_addr;
  logic [15:0] mdio_wr_data, mdio_rd_data;
  logic        mdio_rd_req, mdio_wr_req, mdio_ready;
  logic [1:0]  speed;
  logic        duplex, link, status_valid, init_done, busy, error, link_change;

  phy_cfg_seq #(.DEPTH(32), .PHY_ADDR(5'd0), .STAT_REG(5'd31), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .init_request(init_request), .allow_1Gbit(allow_1Gbit),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_reg(cfg_reg), .cfg_data(cfg_data), .cfg_len(cfg_len),
    .mdio_phy(mdio_phy), .mdio_addr(mdio_addr), .mdio_wr_data(mdio_wr_data),
    .mdio_rd_req(mdio_rd_req), .mdio_wr_req(mdio_wr_req), .mdio_ready(mdio_ready),
    .mdio_rd_data(mdio_rd_data), .speed(speed), .duplex(duplex), .link(link),
    .status_valid(status_valid), .init_done(init_done), .busy(busy), .error(error),
    .link_change(link_change));

  always #5 clock = ~clock;

  typedef struct packed { logic wr; logic [4:0] addr; logic [15:0] data; } acc_t;
  acc_t exp_q[$], obs_q[$];
  int errors = 0, checks = 0, lc_cnt = 0;
  bit eng_dead = 1'b0;
  logic [15:0] stat_val = 16'h0048, reg1_val = 16'h0004;

  always @(negedge clock) if (link_change) lc_cnt++;

  task automatic eng_wait(input int n);
    for (int i = 0; i < n && !reset; i++) begin @(posedge clock); #1; end
  endtask

  // Engine: ready drops 2 clocks after a request is seen, returns 3 clocks later.
  initial begin : engine
    acc_t a;
    mdio_ready = 1'b1;  mdio_rd_data = 16'h0;
    forever begin
      @(posedge clock); #1;
      if (!reset && !eng_dead && mdio_ready && (mdio_rd_req || mdio_wr_req)) begin
        checks++;
        if (mdio_rd_req && mdio_wr_req) begin
          errors++;  $display("FAIL req_onehot got rd=%b wr=%b exp only one", mdio_rd_req, mdio_wr_req);
        end
        a.wr = mdio_wr_req;  a.addr = mdio_addr;  a.data = mdio_wr_req ? mdio_wr_data : 16'h0;
        obs_q.push_back(a);
        eng_wait(2);
        if (!reset) begin
          mdio_ready = 1'b0;
          eng_wait(3);
          if (!reset) begin
            checks++;
            if (mdio_rd_req || mdio_wr_req) begin
              errors++;  $display("FAIL req_drop got rd=%b wr=%b exp 0", mdio_rd_req, mdio_wr_req);
            end
            mdio_rd_data = (a.addr == 5'd31) ? stat_val : (a.addr == 5'd1) ? reg1_val : 16'h0;
          end
        end
        mdio_ready = 1'b1;
      end
    end
  end

  task automatic write_tbl(input logic [4:0] idx, input logic [4:0] r, input logic [15:0] d);
    @(negedge clock);
    cfg_we = 1'b1;  cfg_idx = idx;  cfg_reg = r;  cfg_data = d;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int k = 0;
    while (obs_q.size() < n && k < 2000) begin @(negedge clock); k++; end
  endtask

  task automatic push_init(input logic b9);
    exp_q.push_back(acc_t'{1'b1, 5'd9, {6'h0, b9, 9'h0}});
    exp_q.push_back(acc_t'{1'b1, 5'd0, 16'h1300});
    exp_q.push_back(acc_t'{1'b1, 5'h0d, 16'h0002});
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!init_done && k < 2000) begin @(negedge clock); k++; end
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL %s init_done got=%b exp=1", name, init_done); end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    write_tbl(5'd0, 5'd9, 16'h0000);
    write_tbl(5'd1, 5'd0, 16'h1300);
    write_tbl(5'd2, 5'h0d, 16'h0002);
    @(negedge clock);
    checks++;
    if ({mdio_rd_req, mdio_wr_req, speed, duplex, link, status_valid, init_done, busy, error,
         link_change, mdio_phy, mdio_addr, mdio_wr_data} !== 37'h0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b wr=%b spd=%b dup=%b lnk=%b sv=%b done=%b busy=%b err=%b addr=%h data=%h exp all 0",
               mdio_rd_req, mdio_wr_req, speed, duplex, link, status_valid, init_done, busy, error,
               mdio_addr, mdio_wr_data);
    end
  endtask

  task automatic test_init_seq();
    acc_t e, o;
    push_init(1'b1);
    obs_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL startup_busy got=%b exp=1", busy); end
    wait_obs(3);
    checks++;
    if (obs_q.size() < 3) begin errors++; $display("FAIL init_count got=%0d exp=3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();  checks++;
      if (o !== e) begin
        errors++;  $display("FAIL init_write got=%b:%h:%h exp=%b:%h:%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
    exp_q.delete();
    wait_done("init_seq");
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      errors++;  $display("FAIL init_flags got busy=%b err=%b exp 0 0", busy, error);
    end
  endtask

  task automatic test_status();
    acc_t e, o;
    int k = 0;
    lc_cnt = 0;
    while (!status_valid && k < 500) begin @(negedge clock); k++; end
    obs_q.delete();
    checks++;
    if ({status_valid, speed, duplex, link} !== 5'b1_10_1_1) begin
      errors++;  $display("FAIL status got sv=%b spd=%b dup=%b lnk=%b exp 1 10 1 1", status_valid, speed, duplex, link);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(acc_t'{1'b0, 5'd31, 16'h0});
      exp_q.push_back(acc_t'{1'b0, 5'd1, 16'h0});
    end
    wait_obs(4);
    checks++;
    if (obs_q.size() < 4) begin errors++; $display("FAIL poll_count got=%0d exp=4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();  checks++;
      if (o !== e) begin
        errors++;  $display("FAIL poll_read got=%b:%h exp=%b:%h", o.wr, o.addr, e.wr, e.addr);
      end
    end
    exp_q.delete();
    checks++;
    if (lc_cnt != 1) begin errors++; $display("FAIL link_change_pulses got=%0d exp=1", lc_cnt); end
  endtask

  task automatic test_regen();
    acc_t e, o;
    int k = 0;
    while (!(mdio_rd_req && mdio_addr == 5'd31) && k < 500) begin @(negedge clock); k++; end
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL regen_pre init_done got=%b exp=1", init_done); end
    allow_1Gbit = 1'b0;
    obs_q.delete();
    push_init(1'b0);
    k = 0;
    while (init_done && k < 500) begin @(negedge clock); k++; end
    checks++;
    if (init_done !== 1'b0 || status_valid !== 1'b0) begin
      errors++;  $display("FAIL regen_fall got done=%b sv=%b exp 0 0", init_done, status_valid);
    end
    wait_obs(3);
    checks++;
    if (obs_q.size() < 3) begin errors++; $display("FAIL regen_count got=%0d exp=3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();  checks++;
      if (o !== e) begin
        errors++;  $display("FAIL regen_write got=%b:%h:%h exp=%b:%h:%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
    exp_q.delete();
    wait_done("regen");
  endtask

  task automatic test_init_restart();
    acc_t e, o;
    int k = 0;
    @(negedge clock);  init_request = 1'b1;
    @(negedge clock);  init_request = 1'b0;
    while (init_done && k < 500) begin @(negedge clock); k++; end
    obs_q.delete();
    k = 0;
    while (!(mdio_wr_req && mdio_addr == 5'd0) && k < 500) begin @(negedge clock); k++; end
    init_request = 1'b1;
    cfg_we = 1'b1;  cfg_idx = 5'd0;  cfg_reg = 5'd9;  cfg_data = 16'hFFFF;
    @(negedge clock);
    init_request = 1'b0;  cfg_we = 1'b0;
    exp_q.push_back(acc_t'{1'b1, 5'd9, 16'h0000});
    exp_q.push_back(acc_t'{1'b1, 5'd0, 16'h1300});
    push_init(1'b0);
    wait_obs(5);
    checks++;
    if (obs_q.size() < 5) begin errors++; $display("FAIL restart_count got=%0d exp=5", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();  checks++;
      if (o !== e) begin
        errors++;  $display("FAIL restart_write got=%b:%h:%h exp=%b:%h:%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
    exp_q.delete();
    wait_done("restart");
  endtask

  task automatic test_timeout();
    logic prev, cur;
    int k = 0;
    @(negedge clock);
    eng_dead = 1'b1;
    prev = mdio_rd_req | mdio_wr_req;
    cur = prev;
    while (!(!prev && cur) && k < 500) begin
      prev = cur;  @(posedge clock); #1;  cur = mdio_rd_req | mdio_wr_req;  k++;
    end
    repeat (15) begin @(posedge clock); #1; end
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL timeout_early error got=%b exp=0", error); end
    @(posedge clock); #1;
    checks++;
    if ({error, busy, mdio_rd_req, mdio_wr_req} !== 4'b1100) begin
      errors++;  $display("FAIL timeout got err=%b busy=%b rd=%b wr=%b exp 1 1 0 0", error, busy, mdio_rd_req, mdio_wr_req);
    end
    k = 0;
    while (!(mdio_wr_req && mdio_addr == 5'd9) && k < 100) begin @(negedge clock); k++; end
    checks++;
    if ({mdio_wr_req, mdio_addr, error, busy} !== {1'b1, 5'd9, 1'b1, 1'b1}) begin
      errors++;  $display("FAIL timeout_restart got wr=%b addr=%h err=%b busy=%b exp 1 09 1 1", mdio_wr_req, mdio_addr, error, busy);
    end
    eng_dead = 1'b0;
    wait_done("timeout_recover");
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL error_clear got=%b exp=0", error); end
  endtask

  task automatic test_reset_mid();
    acc_t e, o;
    int k = 0;
    @(negedge clock);  init_request = 1'b1;
    @(negedge clock);  init_request = 1'b0;
    while (!(mdio_wr_req && mdio_addr == 5'd0) && k < 500) begin @(negedge clock); k++; end
    reset = 1'b1;
    #1;
    checks++;
    if ({mdio_rd_req, mdio_wr_req, busy, init_done, error} !== 5'b0) begin
      errors++;  $display("FAIL reset_mid got rd=%b wr=%b busy=%b done=%b err=%b exp 0", mdio_rd_req, mdio_wr_req, busy, init_done, error);
    end
    repeat (3) @(negedge clock);
    obs_q.delete();
    push_init(1'b0);
    reset = 1'b0;
    wait_obs(3);
    checks++;
    if (obs_q.size() < 3) begin errors++; $display("FAIL reset_mid_count got=%0d exp=3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();  checks++;
      if (o !== e) begin
        errors++;  $display("FAIL reset_mid_write got=%b:%h:%h exp=%b:%h:%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
    exp_q.delete();
    wait_done("reset_mid");
  endtask

  initial begin
    init_request = 1'b0;  allow_1Gbit = 1'b1;  cfg_we = 1'b0;
    cfg_idx = '0;  cfg_reg = '0;  cfg_data = '0;  cfg_len = 6'd3;
    test_reset();
    test_init_seq();
    test_status();
    test_regen();
    test_init_restart();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
